alu_acc_sequencer: RTL and testbench

Sequential command front-end for the combinational `ALU_nbit`. It accepts one operation per valid/ready command and applies it to an internal accumulator. It then returns the result and carry/borrow over a valid/ready response channel. It sits between a controller or host-side command stream and the ALU, and provides the registering, operand sequencing and carry chaining that the bare ALU lacks.

---
 rtl/alu_acc_pkg.sv | 26 ++
 rtl/ALU_nbit.sv | 54 +++++
 rtl/alu_acc_sequencer.sv | 119 +++++++++++
 tb/tb_alu_acc_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_acc_pkg.sv
// Shared constants for the accumulator sequencer: ALU mode encodings and FSM states.
package alu_acc_pkg;

  localparam logic [2:0] MODE_ADD = 3'b000;
  localparam logic [2:0] MODE_SUB = 3'b001;
  localparam logic [2:0] MODE_AND = 3'b010;
  localparam logic [2:0] MODE_OR  = 3'b011;
  localparam logic [2:0] MODE_XOR = 3'b100;
  localparam logic [2:0] MODE_NOT = 3'b101;
  localparam logic [2:0] MODE_INC = 3'b110;
  localparam logic [2:0] MODE_DEC = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Command fields other than the width-dependent operand.
  typedef struct packed {
    logic [2:0] mode;
    logic       load;
    logic       chain;
  } cmd_t;

endpackage

// File: rtl/ALU_nbit.sv
// Combinational n-bit ALU: add/sub with carry-borrow in, logic ops, inc/dec.
module ALU_nbit
  import alu_acc_pkg::*;
#(
  parameter int n = 4
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic [2:0]   Mode,
  input  logic         CB_in,
  output logic [n-1:0] Result,
  output logic         CB_out
);

  logic [n:0] sum;
  logic [n:0] cin_ext;

  assign cin_ext = {{n{1'b0}}, CB_in};

  always_comb begin
    sum    = '0;
    Result = '0;
    CB_out = 1'b0;
    case (Mode)
      MODE_ADD: begin
        sum    = {1'b0, A} + {1'b0, B} + cin_ext;
        Result = sum[n-1:0];
        CB_out = sum[n];
      end
      MODE_SUB: begin
        // Top bit of the widened difference is the borrow.
        sum    = {1'b0, A} - {1'b0, B} - cin_ext;
        Result = sum[n-1:0];
        CB_out = sum[n];
      end
      MODE_AND: Result = A & B;
      MODE_OR:  Result = A | B;
      MODE_XOR: Result = A ^ B;
      MODE_NOT: Result = ~A;
      MODE_INC: begin
        sum    = {1'b0, A} + {{n{1'b0}}, 1'b1};
        Result = sum[n-1:0];
        CB_out = sum[n];
      end
      MODE_DEC: begin
        sum    = {1'b0, A} - {{n{1'b0}}, 1'b1};
        Result = sum[n-1:0];
        CB_out = sum[n];
      end
      default: Result = '0;
    endcase
  end

endmodule

// File: rtl/alu_acc_sequencer.sv
// Valid/ready command front-end around ALU_nbit with accumulator and carry chaining.
// Optional zero flag output rsp_zero is built when ALU_ACC_ZFLAG_EN is defined.
module alu_acc_sequencer
  import alu_acc_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_mode,
  input  logic [n-1:0] cmd_operand,
  input  logic         cmd_load,
  input  logic         cmd_chain,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [n-1:0] rsp_result,
`ifdef ALU_ACC_ZFLAG_EN
  output logic         rsp_zero,
`endif
  output logic         rsp_cb
);

  state_t       state_q, state_d;
  cmd_t         cmd_q, cmd_d;
  logic [n-1:0] opnd_q, opnd_d;
  logic [n-1:0] acc_q, acc_d;
  logic         cbf_q, cbf_d;
  logic         rdy_q, rdy_d;
  logic         vld_q, vld_d;
`ifdef ALU_ACC_ZFLAG_EN
  logic         zero_q, zero_d;
`endif

  logic [n-1:0] alu_res;
  logic         alu_cb;

  ALU_nbit #(.n(n)) u_alu (
    .A      (acc_q),
    .B      (opnd_q),
    .Mode   (cmd_q.mode),
    .CB_in  (cmd_q.chain & cbf_q),
    .Result (alu_res),
    .CB_out (alu_cb)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cbf_d   = cbf_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && rdy_q) begin
          cmd_d   = '{mode: cmd_mode, load: cmd_load, chain: cmd_chain};
          opnd_d  = cmd_operand;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cmd_q.load) begin
          acc_d = opnd_q;
          cbf_d = 1'b0;
        end else begin
          acc_d = alu_res;
          cbf_d = alu_cb;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (vld_q && rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake outputs are registered copies of the next state.
    rdy_d = (state_d == ST_IDLE);
    vld_d = (state_d == ST_RESP);
`ifdef ALU_ACC_ZFLAG_EN
    zero_d = (acc_d == '0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cbf_q   <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
`ifdef ALU_ACC_ZFLAG_EN
      zero_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cbf_q   <= cbf_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
`ifdef ALU_ACC_ZFLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign cmd_ready  = rdy_q;
  assign rsp_valid  = vld_q;
  assign rsp_result = acc_q;
  assign rsp_cb     = cbf_q;
`ifdef ALU_ACC_ZFLAG_EN
  assign rsp_zero   = zero_q;
`endif

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Bench for alu_acc_sequencer: directed sequences with literal results plus a
// randomized run checked every cycle against an arithmetic reference model.
module tb_alu_acc_sequencer;

  localparam int N    = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_mode = 3'b000;
  logic [N-1:0] cmd_operand = '0;
  logic         cmd_load = 1'b0;
  logic         cmd_chain = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [N-1:0] rsp_result;
  logic         rsp_cb;
`ifdef ALU_ACC_ZFLAG_EN
  logic         rsp_zero;
`endif

  alu_acc_sequencer #(.n(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_operand (cmd_operand),
    .cmd_load    (cmd_load),
    .cmd_chain   (cmd_chain),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
`ifdef ALU_ACC_ZFLAG_EN
    .rsp_zero    (rsp_zero),
`endif
    .rsp_cb      (rsp_cb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int res;
    int cb;
    int vis;
  } exp_t;

  exp_t q[$];
  int   m_acc = 0;
  int   m_cbf = 0;
  int   since = 0;
  int   ncyc  = 0;
  bit   ev;
  int   r_new, c_new;

  bit rnd_on    = 1'b0;
  bit rdy_force = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: what the accumulator and flag must become for one command.
  function automatic void model_exec(input int mode, input int op, input bit ld,
                                     input bit ch, output int r, output int c);
    int a, cin, t;
    a   = m_acc;
    cin = ch ? m_cbf : 0;
    r   = 0;
    c   = 0;
    if (ld) begin
      r = op;
    end else begin
      case (mode)
        0: begin t = a + op + cin; r = t & MASK; c = (t > MASK) ? 1 : 0; end
        1: begin t = a - op - cin; r = t & MASK; c = (t < 0) ? 1 : 0; end
        2: r = a & op;
        3: r = a | op;
        4: r = a ^ op;
        5: r = (~a) & MASK;
        6: begin r = (a + 1) & MASK; c = (a == MASK) ? 1 : 0; end
        default: begin r = (a - 1) & MASK; c = (a == 0) ? 1 : 0; end
      endcase
    end
    m_acc = r;
    m_cbf = c;
  endfunction

  // Every-cycle comparison against the model; inputs change only after posedge.
  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      check("rst_cmd_ready", int'(cmd_ready), 0);
      check("rst_rsp_valid", int'(rsp_valid), 0);
      check("rst_rsp_result", int'(rsp_result), 0);
      check("rst_rsp_cb", int'(rsp_cb), 0);
`ifdef ALU_ACC_ZFLAG_EN
      check("rst_rsp_zero", int'(rsp_zero), 1);
`endif
      q.delete();
      m_acc = 0;
      m_cbf = 0;
      since = 0;
    end else begin
      ev = (q.size() > 0) && (ncyc >= q[0].vis);
      check("cmd_ready", int'(cmd_ready), (q.size() == 0 && since >= 1) ? 1 : 0);
      check("rsp_valid", int'(rsp_valid), ev ? 1 : 0);
      if (ev) begin
        check("rsp_result", int'(rsp_result), q[0].res);
        check("rsp_cb", int'(rsp_cb), q[0].cb);
`ifdef ALU_ACC_ZFLAG_EN
        check("rsp_zero", int'(rsp_zero), (q[0].res == 0) ? 1 : 0);
`endif
      end
      since++;
      if (ev && rsp_ready) void'(q.pop_front());
      if (cmd_valid && cmd_ready) begin
        model_exec(int'(cmd_mode), int'(cmd_operand), cmd_load, cmd_chain, r_new, c_new);
        q.push_back('{res: r_new, cb: c_new, vis: ncyc + 2});
      end
    end
  end

  always @(posedge clk) begin
    #2;
    rsp_ready = rnd_on ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  task automatic send(input int mode, input int op, input bit ld, input bit ch);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid   = 1'b1;
    cmd_mode    = 3'(mode);
    cmd_operand = N'(op);
    cmd_load    = ld;
    cmd_chain   = ch;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int exp_res, input int exp_cb);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      check({name, "_res"}, int'(rsp_result), exp_res);
      check({name, "_cb"}, int'(rsp_cb), exp_cb);
`ifdef ALU_ACC_ZFLAG_EN
      check({name, "_zero"}, int'(rsp_zero), (exp_res == 0) ? 1 : 0);
`endif
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(0, 4, 1, 0);  wait_rsp("load4", 4, 0);
    send(0, 2, 0, 0);  wait_rsp("add2", 6, 0);
    send(0, 8, 1, 0);  wait_rsp("load8", 8, 0);
    send(0, 14, 0, 0); wait_rsp("add14", 6, 1);
    send(0, 0, 0, 1);  wait_rsp("add0_chain", 7, 0);
    send(0, 5, 1, 0);  wait_rsp("load5", 5, 0);
    send(1, 12, 0, 0); wait_rsp("sub12", 9, 1);
    send(2, 12, 0, 0); wait_rsp("and12", 8, 0);
    send(0, 11, 1, 0); wait_rsp("load11", 11, 0);
    send(5, 0, 0, 0);  wait_rsp("not", 4, 0);
    send(0, 15, 1, 0); wait_rsp("load15", 15, 0);
    send(6, 0, 0, 1);  wait_rsp("inc_wrap", 0, 1);
    send(7, 0, 0, 1);  wait_rsp("dec_wrap", 15, 1);

    // Backpressure: response must hold while the consumer stalls.
    send(0, 2, 1, 0);  wait_rsp("load2", 2, 0);
    rdy_force = 1'b0;
    send(0, 3, 0, 0);  wait_rsp("add3_bp", 5, 0);
    repeat (5) begin
      @(negedge clk);
      check("bp_result", int'(rsp_result), 5);
      check("bp_valid", int'(rsp_valid), 1);
      check("bp_cmd_ready", int'(cmd_ready), 0);
    end
    @(posedge clk);
    #1 rdy_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_ready", int'(cmd_ready), 1);

    // Reset while a load is executing: it must never be delivered.
    send(0, 9, 1, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", int'(rsp_valid), 0);
    check("async_rst_ready", int'(cmd_ready), 0);
    check("async_rst_result", int'(rsp_result), 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    send(0, 1, 0, 0);  wait_rsp("add1_after_rst", 1, 0);

    rnd_on = 1'b1;
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send($urandom_range(0, 7), $urandom_range(0, MASK),
           ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
    end
    rnd_on = 1'b0;
    rdy_force = 1'b1;
    repeat (12) @(negedge clk);
    check("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
